arrow_round_ctrl: RTL and testbench

Round sequencer for the arrow game. Drives the 2-bit game state bus consumed by the LFSR arrow generator. Latches one random arrow code per round and shows it for a timed window. Judges the player's button pulses against the arrow, then updates score and lives and ends the game when no lives remain.

---
 rtl/arrow_round_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_arrow_round_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_round_ctrl.sv
// Round sequencer for the arrow game: latches one arrow per round, times the
// display window, judges button pulses and tracks score, lives and game over.
module arrow_round_ctrl #(
    parameter int WINDOW_TICKS = 8,
    parameter int GAP_TICKS    = 2,
    parameter int LIVES        = 3,
    parameter int SCORE_BITS   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  pause,
    input  logic [3:0]            btn,
    input  logic [4:0]            rand_arrow,
    output logic [1:0]            state,
    output logic [4:0]            arrow,
    output logic [SCORE_BITS-1:0] score,
    output logic [1:0]            lives,
    output logic                  hit,
    output logic                  miss,
    output logic                  game_over,
    output logic [2:0]            dbg_fsm
);

    // Inputs are single-cycle pulses (no valid/ready): each one is acted on in
    // the cycle it is high and never held or queued.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHOW   = 3'd1,
        S_GAP    = 3'd2,
        S_PAUSED = 3'd3,
        S_OVER   = 3'd4
    } fsm_t;

    localparam int TW = $clog2(WINDOW_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [4:0]            ARROW_NONE = 5'd20;
    localparam logic [SCORE_BITS-1:0] SCORE_MAX  = '1;
    localparam logic [1:0]            LIVES_INIT = 2'(LIVES);

    // Required button set, bit order {up, down, left, right}.
    function automatic logic [3:0] arrow_mask(input logic [4:0] code);
        logic [3:0] m;
        case (code)
            5'd10:   m = 4'b1000;
            5'd11:   m = 4'b0100;
            5'd12:   m = 4'b0010;
            5'd13:   m = 4'b0001;
            5'd14:   m = 4'b1100;
            5'd15:   m = 4'b1010;
            5'd16:   m = 4'b1001;
            5'd17:   m = 4'b0110;
            5'd18:   m = 4'b0101;
            5'd19:   m = 4'b0011;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    fsm_t                  fsm_q, fsm_d;
    fsm_t                  saved_q, saved_d;
    logic [4:0]            arrow_q, arrow_d;
    logic [3:0]            mask_q, mask_d;
    logic [3:0]            acc_q, acc_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic [SCORE_BITS-1:0] score_q, score_d;
    logic [1:0]            lives_q, lives_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;

    logic [4:0]    legal_arrow;
    logic [3:0]    acc_next;
    logic [TW-1:0] tcnt_inc;
    logic [GW-1:0] gcnt_inc;
    logic          latch_round;
    logic          win;
    logic          lose;

    assign legal_arrow = (rand_arrow >= 5'd10 && rand_arrow <= 5'd20) ? rand_arrow : ARROW_NONE;
    assign acc_next    = acc_q | btn;
    assign tcnt_inc    = tcnt_q + 1'b1;
    assign gcnt_inc    = gcnt_q + 1'b1;

    always_comb begin
        fsm_d       = fsm_q;
        saved_d     = saved_q;
        arrow_d     = arrow_q;
        mask_d      = mask_q;
        acc_d       = acc_q;
        tcnt_d      = tcnt_q;
        gcnt_d      = gcnt_q;
        score_d     = score_q;
        lives_d     = lives_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        latch_round = 1'b0;
        win         = 1'b0;
        lose        = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (start) latch_round = 1'b1;
            end
            S_SHOW: begin
                // Pause takes the whole cycle: buttons and tick are dropped.
                if (pause) begin
                    saved_d = S_SHOW;
                    fsm_d   = S_PAUSED;
                end else if ((acc_next & ~mask_q) != 4'd0) begin
                    lose = 1'b1;
                end else if (mask_q != 4'd0 && acc_next == mask_q) begin
                    win = 1'b1;
                end else if (tick && tcnt_inc == TW'(WINDOW_TICKS)) begin
                    if (mask_q == 4'd0) win = 1'b1;
                    else                lose = 1'b1;
                end else begin
                    acc_d = acc_next;
                    if (tick) tcnt_d = tcnt_inc;
                end
            end
            S_GAP: begin
                if (pause) begin
                    saved_d = S_GAP;
                    fsm_d   = S_PAUSED;
                end else if (tick) begin
                    if (gcnt_inc == GW'(GAP_TICKS)) latch_round = 1'b1;
                    else                            gcnt_d = gcnt_inc;
                end
            end
            S_PAUSED: begin
                if (pause) fsm_d = saved_q;
            end
            S_OVER: begin
                if (start) begin
                    fsm_d   = S_IDLE;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        if (latch_round) begin
            fsm_d   = S_SHOW;
            arrow_d = legal_arrow;
            mask_d  = arrow_mask(legal_arrow);
            acc_d   = 4'd0;
            tcnt_d  = '0;
            gcnt_d  = '0;
        end

        if (win || lose) begin
            arrow_d = ARROW_NONE;
            mask_d  = 4'd0;
            acc_d   = 4'd0;
            tcnt_d  = '0;
            gcnt_d  = '0;
            fsm_d   = S_GAP;
        end

        if (win) begin
            hit_d = 1'b1;
            if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
        end

        // Losing the last life ends the game instead of starting a gap.
        if (lose) begin
            miss_d  = 1'b1;
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) fsm_d = S_OVER;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            saved_q <= S_SHOW;
            arrow_q <= ARROW_NONE;
            mask_q  <= 4'd0;
            acc_q   <= 4'd0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            saved_q <= saved_d;
            arrow_q <= arrow_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        case (fsm_q)
            S_IDLE:         state = 2'd2;
            S_SHOW, S_GAP:  state = 2'd0;
            default:        state = 2'd1;
        endcase
    end

    assign arrow     = arrow_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign game_over = (fsm_q == S_OVER);
    assign dbg_fsm   = fsm_q;

endmodule

// File: tb/tb_arrow_round_ctrl.sv
// Bench for arrow_round_ctrl: directed game scenarios plus random play,
// every cycle compared against a round-level reference model.
module tb_arrow_round_ctrl;
  localparam int WT = 8;
  localparam int GT = 2;
  localparam int LV = 3;
  localparam int SB = 3;
  localparam int EW = 2 + 5 + SB + 2 + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [3:0]    btn = 4'd0;
  logic [4:0]    rand_arrow = 5'd20;
  logic [1:0]    state;
  logic [4:0]    arrow;
  logic [SB-1:0] score;
  logic [1:0]    lives;
  logic          hit;
  logic          miss;
  logic          game_over;
  logic [2:0]    dbg_fsm;

  arrow_round_ctrl #(
    .WINDOW_TICKS(WT),
    .GAP_TICKS(GT),
    .LIVES(LV),
    .SCORE_BITS(SB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .start(start),
    .pause(pause),
    .btn(btn),
    .rand_arrow(rand_arrow),
    .state(state),
    .arrow(arrow),
    .score(score),
    .lives(lives),
    .hit(hit),
    .miss(miss),
    .game_over(game_over),
    .dbg_fsm(dbg_fsm)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: game rules at round level
  typedef enum int {M_IDLE, M_SHOW, M_GAP, M_PAUSED, M_OVER} mode_t;
  mode_t m_mode = M_IDLE;
  mode_t m_saved = M_SHOW;
  int m_arrow = 20;
  int m_acc = 0;
  int m_ticks = 0;
  int m_gaps = 0;
  int m_score = 0;
  int m_lives = LV;
  int m_hit = 0;
  int m_miss = 0;
  int need_tab[11] = '{8, 4, 2, 1, 12, 10, 9, 6, 5, 3, 0};

  logic [EW-1:0] exp_q[$];

  function automatic int need_of(input int code);
    if (code < 10 || code > 20) return 0;
    return need_tab[code - 10];
  endfunction

  function automatic int shown_state(input mode_t m);
    if (m == M_IDLE) return 2;
    if (m == M_SHOW || m == M_GAP) return 0;
    return 1;
  endfunction

  function automatic void new_round();
    int c;
    c = int'(rand_arrow);
    m_mode  = M_SHOW;
    m_arrow = (c >= 10 && c <= 20) ? c : 20;
    m_acc   = 0;
    m_ticks = 0;
    m_gaps  = 0;
  endfunction

  function automatic void end_round();
    m_arrow = 20;
    m_acc   = 0;
    m_ticks = 0;
    m_gaps  = 0;
  endfunction

  function automatic void model_step();
    int pressed;
    int need;
    bit win;
    bit lose;
    m_hit = 0;
    m_miss = 0;
    win = 0;
    lose = 0;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_score = 0;
      m_lives = LV;
      end_round();
    end else begin
      case (m_mode)
        M_IDLE: if (start) new_round();
        M_SHOW: begin
          if (pause) begin
            m_saved = M_SHOW;
            m_mode = M_PAUSED;
          end else begin
            pressed = m_acc | int'(btn);
            need = need_of(m_arrow);
            if ((pressed & ~need) != 0) lose = 1;
            else if (need != 0 && pressed == need) win = 1;
            else if (m_ticks + int'(tick) >= WT) begin
              if (need == 0) win = 1;
              else lose = 1;
            end else begin
              m_acc = pressed;
              m_ticks += int'(tick);
            end
          end
        end
        M_GAP: begin
          if (pause) begin
            m_saved = M_GAP;
            m_mode = M_PAUSED;
          end else if (tick) begin
            m_gaps++;
            if (m_gaps == GT) new_round();
          end
        end
        M_PAUSED: if (pause) m_mode = m_saved;
        M_OVER: if (start) begin
          m_mode = M_IDLE;
          m_score = 0;
          m_lives = LV;
        end
        default: m_mode = M_IDLE;
      endcase
      if (win) begin
        m_hit = 1;
        if (m_score < (1 << SB) - 1) m_score++;
        end_round();
        m_mode = M_GAP;
      end
      if (lose) begin
        m_miss = 1;
        m_lives--;
        end_round();
        m_mode = (m_lives == 0) ? M_OVER : M_GAP;
      end
    end
    exp_q.push_back({2'(shown_state(m_mode)), 5'(m_arrow), SB'(m_score), 2'(m_lives),
                     1'(m_hit), 1'(m_miss), 1'(m_mode == M_OVER)});
  endfunction

  // scoreboard
  task automatic compare();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("state", state, e[EW-1 -: 2]);
    check("arrow", arrow, e[EW-3 -: 5]);
    check("score", score, e[SB+4 : 5]);
    check("lives", lives, e[4:3]);
    check("hit", hit, e[2]);
    check("miss", miss, e[1]);
    check("game_over", game_over, e[0]);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic cyc(input logic s, input logic p, input logic [3:0] b, input logic t);
    start = s;
    pause = p;
    btn = b;
    tick = t;
    step();
    start = 1'b0;
    pause = 1'b0;
    btn = 4'd0;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic gap_to(input logic [4:0] next_arrow);
    rand_arrow = next_arrow;
    repeat (GT) cyc(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    do_reset();
    check("rst_state", state, 2);
    check("rst_arrow", arrow, 20);
    check("rst_lives", lives, LV);

    // first round: two-button arrow won by separate pulses
    rand_arrow = 5'd16;
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    check("start_state", state, 0);
    check("start_arrow", arrow, 16);
    cyc(1'b0, 1'b0, 4'b1000, 1'b0);
    cyc(1'b0, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 4'b0001, 1'b0);
    check("hit_16", hit, 1);
    check("score_1", score, 1);
    check("arrow_cleared", arrow, 20);

    // wrong button
    gap_to(5'd10);
    check("show_10", arrow, 10);
    cyc(1'b0, 1'b0, 4'b0100, 1'b0);
    check("miss_10", miss, 1);
    check("lives_2", lives, 2);
    check("score_kept", score, 1);

    // NONE arrow wins on timeout, single arrow loses on timeout
    gap_to(5'd20);
    repeat (WT - 1) cyc(1'b0, 1'b0, 4'd0, 1'b1);
    check("none_not_early", hit, 0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1);
    check("hit_none", hit, 1);
    gap_to(5'd13);
    repeat (WT) cyc(1'b0, 1'b0, 4'd0, 1'b1);
    check("miss_timeout", miss, 1);
    check("lives_1", lives, 1);

    // button arriving with the expiring tick
    gap_to(5'd12);
    repeat (WT - 1) cyc(1'b0, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 4'b0010, 1'b1);
    check("hit_edge", hit, 1);
    check("no_miss_edge", miss, 0);

    // pause freezes the window at tick count 5
    gap_to(5'd11);
    repeat (5) cyc(1'b0, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'd0, 1'b0);
    check("paused_state", state, 1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 4'(1 << (i % 4)), 1'b1);
    check("paused_arrow", arrow, 11);
    check("paused_lives", lives, 1);
    cyc(1'b0, 1'b1, 4'd0, 1'b0);
    check("resumed_state", state, 0);
    repeat (2) cyc(1'b0, 1'b0, 4'd0, 1'b1);
    check("resume_no_miss", miss, 0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1);
    check("resume_miss", miss, 1);
    check("over_flag", game_over, 1);
    check("over_state", state, 1);
    check("over_lives", lives, 0);
    cyc(1'b0, 1'b1, 4'd0, 1'b0);
    check("over_pause_ignored", state, 1);
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    check("idle_state", state, 2);
    check("idle_score", score, 0);
    check("idle_lives", lives, LV);

    // three consecutive misses
    rand_arrow = 5'd10;
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'b0001, 1'b0);
    gap_to(5'd10);
    cyc(1'b0, 1'b0, 4'b0001, 1'b0);
    gap_to(5'd10);
    cyc(1'b0, 1'b0, 4'b0001, 1'b0);
    check("over3_flag", game_over, 1);
    check("over3_lives", lives, 0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0);

    // reset mid-round
    rand_arrow = 5'd15;
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'b1000, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_state", state, 2);
    check("midrst_arrow", arrow, 20);
    check("midrst_lives", lives, LV);

    // score saturation, with an out-of-range code latched as NONE
    rand_arrow = 5'd14;
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < (1 << SB) + 1; i++) begin
      cyc(1'b0, 1'b0, 4'b1100, 1'b0);
      gap_to(5'd14);
    end
    check("score_sat", score, (1 << SB) - 1);
    cyc(1'b0, 1'b1, 4'b1100, 1'b0);
    check("pause_drops_btn", hit, 0);
    cyc(1'b0, 1'b1, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'b1100, 1'b0);
    gap_to(5'd25);
    check("illegal_code", arrow, 20);

    // random play
    for (int i = 0; i < 5000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      rand_arrow = 5'($urandom_range(6, 24));
      start = ($urandom_range(0, 15) == 0);
      pause = ($urandom_range(0, 39) == 0);
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) btn = 4'(need_of(m_arrow));
      else if ($urandom_range(0, 5) == 0) btn = 4'(1 << $urandom_range(0, 3));
      else btn = 4'd0;
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    tick = 1'b0;
    btn = 4'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
